fifo_sched: RTL and testbench



---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_sched_rr_arb2.sv | 40 ++++
 rtl/fifo_sched.sv | 136 +++++++++++++
 tb/tb_fifo_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO and its access scheduler.
// Holds the FIFO geometry, the FIFO's own state encodings and the scheduler's.
package fifo_pkg;

    localparam int DEPTH  = 8;
    localparam int CWIDTH = 4;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        READ     = 3'd3,
        WR_ERROR = 3'd4,
        RD_ERROR = 3'd5
    } fifo_state_t;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } sched_state_t;

    // Class favoured on the next write/read collision.
    typedef enum logic {
        TOK_WR = 1'b0,
        TOK_RD = 1'b1
    } tok_t;

endpackage

// File: rtl/fifo_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past whichever port was granted.
// Grants are combinational and only issued while i_en is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    // Grant selection: pointer only matters when both ports request
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = r_ptr ? 2'b10 : 2'b01;
            end else begin
                o_gnt = i_req;
            end
        end else begin
            o_gnt = 2'b00;
        end
    end

    // Pointer update after each grant
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (o_gnt[0]) begin
            r_ptr <= 1'b1;
        end else if (o_gnt[1]) begin
            r_ptr <= 1'b0;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/fifo_sched.sv
// Access scheduler for the 8-entry FIFO: serialises two producers and one consumer
// onto single-operation-per-cycle FIFO strobes, tracks occupancy and drains on flush.
module fifo_sched #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int CWIDTH = fifo_pkg::CWIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req0,
    input  logic              wr_req1,
    input  logic [DWIDTH-1:0] wr_din0,
    input  logic [DWIDTH-1:0] wr_din1,
    output logic              wr_gnt0,
    output logic              wr_gnt1,
    input  logic              rd_req,
    output logic              rd_gnt,
    input  logic              flush,
    output logic              flush_done,
    output logic              fifo_wr_en,
    output logic              fifo_rd_en,
    output logic [DWIDTH-1:0] fifo_din,
    output logic [CWIDTH-1:0] count,
    output logic              full,
    output logic              empty
);
    import fifo_pkg::*;

    sched_state_t      r_state, w_state_nxt;
    tok_t              r_tok, w_tok_nxt;
    logic [CWIDTH-1:0] r_count, w_count_nxt;
    logic              r_wr_en, r_rd_en, r_flush_done;
    logic [DWIDTH-1:0] r_din;
    logic              w_full, w_empty, w_wcand, w_rcand;
    logic              w_wr_win, w_rd_win, w_rd_en_nxt, w_done_nxt;
    logic [1:0]        w_gnt;
    logic [DWIDTH-1:0] w_din_sel;

    assign w_full  = (r_count == CWIDTH'(DEPTH));
    assign w_empty = (r_count == {CWIDTH{1'b0}});
    assign w_wcand = (wr_req0 | wr_req1) & ~w_full;
    assign w_rcand = rd_req & ~w_empty;

    // Next state, class arbitration, occupancy and drain control
    always_comb begin
        w_state_nxt = r_state;
        w_tok_nxt   = r_tok;
        w_count_nxt = r_count;
        w_wr_win    = 1'b0;
        w_rd_win    = 1'b0;
        w_rd_en_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_INIT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_wr_win = w_wcand & (~w_rcand | (r_tok == TOK_WR));
                    w_rd_win = w_rcand & (~w_wcand | (r_tok == TOK_RD));
                    // On a collision the losing class is favoured next time
                    if (w_wcand & w_rcand) begin
                        w_tok_nxt = w_wr_win ? TOK_RD : TOK_WR;
                    end else begin
                        w_tok_nxt = r_tok;
                    end
                    if (w_wr_win) begin
                        w_count_nxt = r_count + CWIDTH'(1);
                    end else if (w_rd_win) begin
                        w_count_nxt = r_count - CWIDTH'(1);
                    end else begin
                        w_count_nxt = r_count;
                    end
                    w_rd_en_nxt = w_rd_win;
                end
            end
            S_FLUSH: begin
                if (!w_empty) begin
                    w_rd_en_nxt = 1'b1;
                    w_count_nxt = r_count - CWIDTH'(1);
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   ({wr_req1, wr_req0}),
        .i_en    (w_wr_win),
        .o_gnt   (w_gnt)
    );

    assign w_din_sel = w_gnt[1] ? wr_din1 : wr_din0;

    // State, occupancy and registered FIFO strobes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_INIT;
            r_tok        <= TOK_WR;
            r_count      <= {CWIDTH{1'b0}};
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_din        <= {DWIDTH{1'b0}};
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tok        <= w_tok_nxt;
            r_count      <= w_count_nxt;
            r_wr_en      <= w_wr_win;
            r_rd_en      <= w_rd_en_nxt;
            r_flush_done <= w_done_nxt;
            r_din        <= w_wr_win ? w_din_sel : r_din;
        end
    end

    assign wr_gnt0    = w_gnt[0];
    assign wr_gnt1    = w_gnt[1];
    assign rd_gnt     = w_rd_win;
    assign fifo_wr_en = r_wr_en;
    assign fifo_rd_en = r_rd_en;
    assign fifo_din   = r_din;
    assign flush_done = r_flush_done;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;

endmodule

// File: tb/tb_fifo_sched.sv
// Directed bench for fifo_sched: reset, producer fairness, full/empty blocking,
// read/write contention, flush drain and reset during flush.
module tb_fifo_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_req0, wr_req1, rd_req, flush;
    logic [31:0] wr_din0, wr_din1;
    logic        wr_gnt0, wr_gnt1, rd_gnt, flush_done;
    logic        fifo_wr_en, fifo_rd_en;
    logic [31:0] fifo_din;
    logic [3:0]  count;
    logic        full, empty;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_sched #(.DWIDTH(32), .DEPTH(8), .CWIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_req0    (wr_req0),
        .wr_req1    (wr_req1),
        .wr_din0    (wr_din0),
        .wr_din1    (wr_din1),
        .wr_gnt0    (wr_gnt0),
        .wr_gnt1    (wr_gnt1),
        .rd_req     (rd_req),
        .rd_gnt     (rd_gnt),
        .flush      (flush),
        .flush_done (flush_done),
        .fifo_wr_en (fifo_wr_en),
        .fifo_rd_en (fifo_rd_en),
        .fifo_din   (fifo_din),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_din;
        reset_n = 1'b0;
        wr_req0 = 1'b0; wr_req1 = 1'b0; rd_req = 1'b0; flush = 1'b0;
        wr_din0 = 32'h0; wr_din1 = 32'h0;
        tick();
        tick();
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_din", fifo_din, 32'd0);
        check("rst_done", {31'd0, flush_done}, 32'd0);

        // INIT cycle: requests present but nothing granted
        reset_n = 1'b1;
        wr_req0 = 1'b1; wr_req1 = 1'b1;
        wr_din0 = 32'hA0; wr_din1 = 32'hB0;
        #4;
        check("init_gnt0", {31'd0, wr_gnt0}, 32'd0);
        check("init_gnt1", {31'd0, wr_gnt1}, 32'd0);
        tick();

        // Fairness: A0,B0,A1,B1,... until full
        for (int k = 0; k < 8; k++) begin
            #4;
            check("fair_gnt0", {31'd0, wr_gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("fair_gnt1", {31'd0, wr_gnt1}, (k % 2 == 0) ? 32'd0 : 32'd1);
            check("fair_rdgnt", {31'd0, rd_gnt}, 32'd0);
            tick();
            exp_din = ((k % 2 == 0) ? 32'hA0 : 32'hB0) + 32'(k / 2);
            check("fair_wr_en", {31'd0, fifo_wr_en}, 32'd1);
            check("fair_din", fifo_din, exp_din);
            check("fair_count", {28'd0, count}, 32'(k + 1));
            if (k % 2 == 0) wr_din0 = wr_din0 + 32'd1;
            else            wr_din1 = wr_din1 + 32'd1;
        end
        check("full_flag", {31'd0, full}, 32'd1);
        check("full_empty", {31'd0, empty}, 32'd0);
        #4;
        check("full_gnt0", {31'd0, wr_gnt0}, 32'd0);
        check("full_gnt1", {31'd0, wr_gnt1}, 32'd0);
        wr_req1 = 1'b0;
        #1;
        check("full_gnt0_single", {31'd0, wr_gnt0}, 32'd0);
        tick();
        check("full_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("full_count", {28'd0, count}, 32'd8);

        // Drain to 4 with reads only
        wr_req0 = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4;
            check("drain_rdgnt", {31'd0, rd_gnt}, 32'd1);
            tick();
            check("drain_rd_en", {31'd0, fifo_rd_en}, 32'd1);
            check("drain_count", {28'd0, count}, 32'(7 - i));
        end

        // Contention: write first (token favours writes after reset)
        wr_req0 = 1'b1; rd_req = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #4;
            check("cont_wgnt", {31'd0, wr_gnt0}, (j % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_rgnt", {31'd0, rd_gnt}, (j % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            check("cont_count", {28'd0, count}, (j % 2 == 0) ? 32'd5 : 32'd4);
            check("cont_wr_en", {31'd0, fifo_wr_en}, (j % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_rd_en", {31'd0, fifo_rd_en}, (j % 2 == 0) ? 32'd0 : 32'd1);
            check("cont_excl", {31'd0, fifo_wr_en & fifo_rd_en}, 32'd0);
        end

        // Bring count to 5, then flush with a write request pending
        rd_req = 1'b0;
        tick();
        check("pre_flush_count", {28'd0, count}, 32'd5);
        flush = 1'b1;
        #4;
        check("flush_cycle_gnt", {31'd0, wr_gnt0}, 32'd0);
        tick();
        flush = 1'b0;
        rd_req = 1'b1;
        check("flush_entry_count", {28'd0, count}, 32'd5);
        check("flush_entry_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            #4;
            check("flush_wgnt", {31'd0, wr_gnt0}, 32'd0);
            check("flush_rgnt", {31'd0, rd_gnt}, 32'd0);
            tick();
            check("flush_rd_en", {31'd0, fifo_rd_en}, 32'd1);
            check("flush_wr_en", {31'd0, fifo_wr_en}, 32'd0);
            check("flush_count", {28'd0, count}, 32'(5 - i));
            check("flush_done_early", {31'd0, flush_done}, 32'd0);
        end
        #4;
        check("flush_last_wgnt", {31'd0, wr_gnt0}, 32'd0);
        tick();
        check("flush_done", {31'd0, flush_done}, 32'd1);
        check("flush_done_rd_en", {31'd0, fifo_rd_en}, 32'd0);

        // Back in RUN: read at empty is blocked, done is a single pulse
        wr_req0 = 1'b0;
        #4;
        check("empty_rdgnt", {31'd0, rd_gnt}, 32'd0);
        tick();
        check("empty_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("done_pulse_once", {31'd0, flush_done}, 32'd0);
        check("empty_count", {28'd0, count}, 32'd0);

        // Grants re-enabled: write three entries
        rd_req = 1'b0; wr_req0 = 1'b1;
        #4;
        check("run_wgnt", {31'd0, wr_gnt0}, 32'd1);
        tick();
        tick();
        tick();
        check("refill_count", {28'd0, count}, 32'd3);

        // Reset while in FLUSH with count 3
        wr_req0 = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("rflush_count", {28'd0, count}, 32'd3);
        reset_n = 1'b0;
        tick();
        check("rflush_rst_count", {28'd0, count}, 32'd0);
        check("rflush_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rflush_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("rflush_rst_done", {31'd0, flush_done}, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rflush_after_done", {31'd0, flush_done}, 32'd0);
            check("rflush_after_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            check("rflush_after_count", {28'd0, count}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
